// File: rtl/avalon_gen_pkg.sv
// Shared types and helpers for the Avalon-ST packet generator.
// Beat and empty arithmetic is kept here so the top and benches agree on it.
package avalon_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } gen_sm_t;

    // Default beat width; the top derives its own empty width from its parameter.
    localparam int GEN_W   = 16;
    localparam int EMPTY_W = $clog2(GEN_W);

    function automatic int unsigned calc_beats(input int unsigned len, input int unsigned w);
        return (len + w - 1) / w;
    endfunction

    function automatic int unsigned calc_empty(input int unsigned len, input int unsigned w);
        return calc_beats(len, w) * w - len;
    endfunction

endpackage

// File: rtl/avalon_gen_pattern_beat.sv
// Combinational beat builder: byte j of beat i is seed + i*W + j (mod 256),
// first byte in the MSBs; trailing empty bytes of the last beat are zeroed.
module avalon_pattern_beat #(
    parameter int BYTES = 16,
    parameter int IDX_W = 16,
    parameter int EW    = 4
) (
    input  logic [7:0]         seed,
    input  logic [IDX_W-1:0]   beat_idx,
    input  logic               last,
    input  logic [EW-1:0]      empty,
    output logic [8*BYTES-1:0] data
);

    logic [7:0] base;

    always_comb begin
        base = seed + 8'(beat_idx * IDX_W'(BYTES));
        data = '0;
        for (int j = 0; j < BYTES; j++) begin
            if (!last || (j + int'(empty)) < BYTES)
                data[8*(BYTES-1-j) +: 8] = base + 8'(j);
        end
    end

endmodule

// File: rtl/avalon_msg_generator.sv
// Avalon-ST packet source: one {len, seed} command becomes one sop..eop packet.
// Optional stats counters (pkt_cnt, drop_cnt) under AVALON_GEN_STATS_EN.
module avalon_msg_generator
    import avalon_gen_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_rdy,
    input  logic [LEN_WIDTH-1:0]               cmd_len_bytes,
    input  logic [7:0]                         cmd_seed,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0]   msg_out_data,
    output logic                               msg_out_valid,
    input  logic                               msg_out_rdy,
    output logic                               msg_out_sop,
    output logic                               msg_out_eop,
    output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] msg_out_empty,
    output logic                               zero_len_indi,
    output logic                               busy
`ifdef AVALON_GEN_STATS_EN
    ,
    output logic [31:0]                        pkt_cnt,
    output logic [15:0]                        drop_cnt
`endif
);

    localparam int W  = DATA_WIDTH_IN_BYTES;
    localparam int DW = 8 * W;
    localparam int EW = $clog2(W);
    localparam int LW = LEN_WIDTH;

    gen_sm_t        state_q, state_d;
    logic [7:0]     seed_q, seed_d;
    logic [LW-1:0]  beats_q, beats_d;
    logic [LW-1:0]  beat_q, beat_d;
    logic [EW-1:0]  lempty_q, lempty_d;
    logic           valid_q, valid_d;
    logic           sop_q, sop_d;
    logic           eop_q, eop_d;
    logic [EW-1:0]  empty_q, empty_d;
    logic [DW-1:0]  data_q, data_d;
    logic           zlen_q, zlen_d;
    logic           cmd_rdy_q, cmd_rdy_d;

    logic [LW-1:0]  cmd_beats;
    logic [EW-1:0]  cmd_empty;
    logic [7:0]     pat_seed;
    logic [LW-1:0]  pat_idx;
    logic           pat_last;
    logic [EW-1:0]  pat_empty;
    logic [DW-1:0]  pat_data;
    logic           eop_hs, drop_ev;

    assign cmd_beats = LW'(calc_beats(32'(cmd_len_bytes), W));
    assign cmd_empty = EW'(calc_empty(32'(cmd_len_bytes), W));

    avalon_pattern_beat #(.BYTES(W), .IDX_W(LW), .EW(EW)) u_beat (
        .seed     (pat_seed),
        .beat_idx (pat_idx),
        .last     (pat_last),
        .empty    (pat_empty),
        .data     (pat_data)
    );

    // The beat builder always looks one beat ahead: beat 0 of the incoming
    // command in IDLE, beat_q+1 of the latched packet in SEND.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        beats_d   = beats_q;
        beat_d    = beat_q;
        lempty_d  = lempty_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        empty_d   = empty_q;
        data_d    = data_q;
        zlen_d    = 1'b0;
        eop_hs    = 1'b0;
        drop_ev   = 1'b0;
        pat_seed  = cmd_seed;
        pat_idx   = '0;
        pat_last  = (cmd_beats == LW'(1));
        pat_empty = cmd_empty;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_rdy_q) begin
                    if (cmd_len_bytes == '0) begin
                        zlen_d  = 1'b1;
                        drop_ev = 1'b1;
                    end else begin
                        state_d  = SEND;
                        seed_d   = cmd_seed;
                        beats_d  = cmd_beats;
                        lempty_d = cmd_empty;
                        beat_d   = '0;
                        valid_d  = 1'b1;
                        sop_d    = 1'b1;
                        eop_d    = pat_last;
                        empty_d  = pat_last ? cmd_empty : '0;
                        data_d   = pat_data;
                    end
                end
            end
            SEND: begin
                pat_seed  = seed_q;
                pat_idx   = beat_q + LW'(1);
                pat_last  = (beat_q + LW'(2)) == beats_q;
                pat_empty = lempty_q;
                if (msg_out_rdy) begin
                    if (eop_q) begin
                        eop_hs  = 1'b1;
                        state_d = IDLE;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        empty_d = '0;
                        data_d  = '0;
                    end else begin
                        beat_d  = pat_idx;
                        sop_d   = 1'b0;
                        eop_d   = pat_last;
                        empty_d = pat_last ? lempty_q : '0;
                        data_d  = pat_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            seed_q    <= '0;
            beats_q   <= '0;
            beat_q    <= '0;
            lempty_q  <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            empty_q   <= '0;
            data_q    <= '0;
            zlen_q    <= 1'b0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            beats_q   <= beats_d;
            beat_q    <= beat_d;
            lempty_q  <= lempty_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            empty_q   <= empty_d;
            data_q    <= data_d;
            zlen_q    <= zlen_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd_rdy       = cmd_rdy_q;
    assign msg_out_data  = data_q;
    assign msg_out_valid = valid_q;
    assign msg_out_sop   = sop_q;
    assign msg_out_eop   = eop_q;
    assign msg_out_empty = empty_q;
    assign zero_len_indi = zlen_q;
    assign busy          = (state_q == SEND);

`ifdef AVALON_GEN_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + 32'(eop_hs);
        drop_cnt_d = drop_cnt_q;
        if (drop_ev && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_ev;
    assign unused_ev = eop_hs ^ drop_ev;
`endif

endmodule
